// File: rtl/bmult_pkg.sv
// Shared widths, FSM encoding and in-flight tag type for the Bmult16x16 MAC stage.
package bmult_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 2 * OP_W;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACC       = 2'd1,
        WAIT_LAST = 2'd2
    } bmult_acc_state_t;

    typedef struct packed {
        logic v;
        logic last;
    } bmult_tag_t;

endpackage

// File: rtl/bmult_tag_pipe.sv
// Shift register carrying {valid, last} alongside the multiplier so that the
// output stage sees a tag in exactly the cycle its product appears on mult_p.
import bmult_pkg::*;

module bmult_tag_pipe #(
    parameter int MULT_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  bmult_tag_t tag_in,
    output bmult_tag_t tag_out,
    output logic       last_inflight
);

    bmult_tag_t           stage_reg [0:MULT_LAT];
    logic [MULT_LAT:0]    last_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MULT_LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i <= MULT_LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    for (genvar gi = 0; gi <= MULT_LAT; gi++) begin : g_last
        assign last_bits[gi] = stage_reg[gi].last;
    end

    assign tag_out       = stage_reg[MULT_LAT];
    assign last_inflight = |last_bits;

endmodule

// File: rtl/bmult_acc_stage.sv
// Streaming front/back end for the Bmult16x16 multiplier: registers operands,
// tracks in-flight products and accumulates them into per-frame results.
import bmult_pkg::*;

module bmult_acc_stage #(
    parameter int OP_W     = bmult_pkg::OP_W,
    parameter int PROD_W   = bmult_pkg::PROD_W,
    parameter int ACC_W    = bmult_pkg::ACC_W,
    parameter int CNT_W    = bmult_pkg::CNT_W,
    parameter int MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic [OP_W-1:0]   mult_a,
    output logic [OP_W-1:0]   mult_b,
    input  logic [PROD_W-1:0] mult_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    localparam int AW1 = ACC_W + 1;

    bmult_acc_state_t state_reg, state_next;
    bmult_tag_t       tag_in, tag_out;
    logic             last_inflight;
    logic             ready_en_reg;
    logic             accept;
    logic             closing;
    logic             accumulating;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic [AW1-1:0]   sum;
    logic [CNT_W-1:0] cnt_inc;

    // Only one frame end may be in flight, and a stalled result blocks new input.
    assign in_ready = ready_en_reg && !last_inflight && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign tag_in   = '{v: accept, last: accept && in_last};

    assign sum     = AW1'(acc_reg) + AW1'(mult_p);
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    bmult_tag_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_tag_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .tag_in        (tag_in),
        .tag_out       (tag_out),
        .last_inflight (last_inflight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = in_last ? WAIT_LAST : ACC;
            ACC:       if (accept && in_last) state_next = WAIT_LAST;
            WAIT_LAST: if (tag_out.v && tag_out.last) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        closing      = 1'b0;
        accumulating = 1'b0;
        if (tag_out.v) begin
            if (tag_out.last) begin
                closing = (state_reg == WAIT_LAST);
            end else begin
                accumulating = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
            mult_a       <= '0;
            mult_b       <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept) begin
                mult_a <= in_a;
                mult_b <= in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (closing) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (accumulating) begin
            acc_reg <= sum[ACC_W-1:0];
            cnt_reg <= cnt_inc;
            ovf_reg <= ovf_reg | sum[ACC_W];
        end
    end

    // A close in the same cycle as an output handshake reloads and keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (closing) begin
            out_valid <= 1'b1;
            out_acc   <= sum[ACC_W-1:0];
            out_cnt   <= cnt_inc;
            out_ovf   <= ovf_reg | sum[ACC_W];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bmult_acc_stage.sv
// Bench for bmult_acc_stage: a 48-bit and a 32-bit accumulator instance share the
// input stream, each paired with a 1-cycle multiplier model, checked by a scoreboard.
module tb_bmult_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, in_ready32;
    logic [15:0] mult_a, mult_b, mult_a32, mult_b32;
    logic [31:0] mult_p, mult_p32;
    logic        out_valid, out_valid32;
    logic [47:0] out_acc;
    logic [31:0] out_acc32;
    logic [15:0] out_cnt, out_cnt32;
    logic        out_ovf, out_ovf32;

    typedef struct {
        logic [47:0] acc48;
        logic [31:0] acc32;
        logic [15:0] cnt;
        logic        ovf48;
        logic        ovf32;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] frame_sum = '0;
    int          frame_n = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        mult_p   <= 32'(mult_a) * 32'(mult_b);
        mult_p32 <= 32'(mult_a32) * 32'(mult_b32);
    end

    bmult_acc_stage #(.ACC_W(48), .MULT_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    bmult_acc_stage #(.ACC_W(32), .MULT_LAT(1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mult_a(mult_a32), .mult_b(mult_b32), .mult_p(mult_p32),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_acc(out_acc32), .out_cnt(out_cnt32), .out_ovf(out_ovf32)
    );

    // Scoreboard: compare every completed output handshake against the model.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got acc=%h cnt=%0d, required no output", out_acc, out_cnt);
                miscompares++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("frame out: acc48=%h acc32=%h cnt=%0d ovf48=%b ovf32=%b", out_acc, out_acc32, out_cnt, out_ovf, out_ovf32);
                if (out_acc !== e.acc48) begin
                    $display("FAIL sb_acc48: got %h, required %h", out_acc, e.acc48); miscompares++;
                end
                vectors++;
                if (out_cnt !== e.cnt) begin
                    $display("FAIL sb_cnt: got %0d, required %0d", out_cnt, e.cnt); miscompares++;
                end
                vectors++;
                if (out_ovf !== e.ovf48) begin
                    $display("FAIL sb_ovf48: got %b, required %b", out_ovf, e.ovf48); miscompares++;
                end
                vectors++;
                if (out_valid32 !== 1'b1 || out_acc32 !== e.acc32 || out_ovf32 !== e.ovf32 || out_cnt32 !== e.cnt) begin
                    $display("FAIL sb_acc32: got v=%b acc=%h ovf=%b cnt=%0d, required v=1 acc=%h ovf=%b cnt=%0d",
                             out_valid32, out_acc32, out_ovf32, out_cnt32, e.acc32, e.ovf32, e.cnt);
                    miscompares++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last, output int waited);
        waited = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            miscompares++;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        frame_sum = frame_sum + 64'(a) * 64'(b);
        frame_n++;
        if (last) begin
            exp_t e;
            e.acc48 = frame_sum[47:0];
            e.acc32 = frame_sum[31:0];
            e.ovf48 = (frame_sum[63:48] != 0);
            e.ovf32 = (frame_sum[63:32] != 0);
            e.cnt   = (frame_n > 65535) ? 16'hFFFF : 16'(frame_n);
            exp_q.push_back(e);
            frame_sum = '0;
            frame_n = 0;
        end
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
            miscompares++;
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_acc, out_cnt, out_ovf, mult_a, mult_b, in_ready} !== '0) begin
            $display("FAIL reset_outputs: got v=%b acc=%h cnt=%h ovf=%b ma=%h mb=%h rdy=%b, required all 0",
                     out_valid, out_acc, out_cnt, out_ovf, mult_a, mult_b, in_ready);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_ready_early: got %b, required 0", in_ready); miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready_rise: got %b, required 1", in_ready); miscompares++;
        end
    endtask

    task automatic test_single();
        int w;
        out_ready = 1'b0;
        send(16'd3, 16'd5, 1'b1, w);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_lat1: out_valid=%b, required 0", out_valid); miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_lat2: out_valid=%b, required 0", out_valid); miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_acc !== 48'd15 || out_cnt !== 16'd1 || out_ovf !== 1'b0) begin
            $display("FAIL single_lat3: got v=%b acc=%0d cnt=%0d ovf=%b, required v=1 acc=15 cnt=1 ovf=0",
                     out_valid, out_acc, out_cnt, out_ovf);
            miscompares++;
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF, 16'hFFFF, (i == 3), w);
            vectors++;
            if (w != 0) begin
                $display("FAIL b2b_ready: pair %0d waited %0d cycles, required 0", i, w); miscompares++;
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w, n;
        out_ready = 1'b0;
        send(16'd2, 16'd2, 1'b1, w);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        in_a = 16'd7; in_b = 16'd7; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 48'd4) begin
                $display("FAIL bp_hold: cycle %0d rdy=%b v=%b acc=%0d, required rdy=0 v=1 acc=4",
                         i, in_ready, out_valid, out_acc);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'd7, 16'd7, 1'b1, w);
        drain();
    endtask

    task automatic test_acc32_wrap();
        int w, n;
        out_ready = 1'b0;
        send(16'hFFFF, 16'hFFFF, 1'b0, w);
        send(16'hFFFF, 16'hFFFF, 1'b1, w);
        n = 0;
        while (!out_valid32 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (out_acc32 !== 32'hFFFC_0002 || out_ovf32 !== 1'b1 || out_ovf !== 1'b0) begin
            $display("FAIL wrap32: got acc32=%h ovf32=%b ovf48=%b, required acc32=fffc0002 ovf32=1 ovf48=0",
                     out_acc32, out_ovf32, out_ovf);
            miscompares++;
        end
        out_ready = 1'b1;
        drain();
        send(16'd1, 16'd1, 1'b1, w);
        drain();
    endtask

    task automatic test_reset_midframe();
        int w;
        out_ready = 1'b1;
        send(16'd11, 16'd13, 1'b0, w);
        send(16'd17, 16'd19, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_acc, out_cnt, out_ovf, mult_a, mult_b, in_ready} !== '0) begin
            $display("FAIL midreset_outputs: got v=%b acc=%h cnt=%h ovf=%b ma=%h mb=%h rdy=%b, required all 0",
                     out_valid, out_acc, out_cnt, out_ovf, mult_a, mult_b, in_ready);
            miscompares++;
        end
        frame_sum = '0;
        frame_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'd6, 16'd7, 1'b1, w);
        drain();
    endtask

    task automatic test_gaps();
        int w, gap;
        logic [15:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            send(a, b, (i == 9), w);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                vectors++;
                if (mult_a !== a || mult_b !== b) begin
                    $display("FAIL gap_hold: got ma=%h mb=%h, required ma=%h mb=%h", mult_a, mult_b, a, b);
                    miscompares++;
                end
                @(posedge clk); #1;
            end
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_acc32_wrap();
        test_reset_midframe();
        test_gaps();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
